// File: rtl/fp_mac_feeder_pkg.sv
// fp_mac_feeder_pkg: FP operand field widths and feeder FSM state encoding shared across the fp_mac lane
package fp_mac_feeder_pkg;
  localparam int FP_EXP   = 4;
  localparam int FP_MTS   = 3;
  localparam int FP_WIDTH = FP_EXP + FP_MTS + 1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADW,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_QUIET
  } state_t;
endpackage

// File: rtl/fp_mac_feeder_buf.sv
// fp_mac_feeder_buf: K x WIDTH register file with one write port and one combinational read port
module fp_mac_feeder_buf
  import fp_mac_feeder_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int K     = 9,
  localparam int AW   = $clog2(K)
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [K];
  // Write port; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/fp_mac_feeder.sv
// fp_mac_feeder: operand sequencer for one fp_mac lane; optional WAIT timeout under FP_MAC_FEED_TIMEOUT_EN
module fp_mac_feeder
  import fp_mac_feeder_pkg::*;
#(
  parameter int WIDTH   = FP_WIDTH,
  parameter int K       = 9,
  parameter int GAP     = 12,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             w_vld,
  output logic             w_rdy,
  input  logic [WIDTH-1:0] w_data,
  input  logic             d_vld,
  output logic             d_rdy,
  input  logic [WIDTH-1:0] d_data,
  output logic             mac_vld_o,
  output logic [WIDTH-1:0] mac_win,
  output logic [WIDTH-1:0] mac_din,
  input  logic [WIDTH-1:0] mac_acc_i,
  input  logic             mac_vld_i,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             err_timeout
);
  localparam int WK = $clog2(K);
  localparam int GW = $clog2(GAP + 1);
  state_t state, nxt;
  logic [WK:0] idx;
  logic [GW-1:0] gcnt;
  logic loaded, last, w_fire, d_fire, tmo, gap_done;
  logic [WIDTH-1:0] w_rd, d_rd;
  if (K < 2 || GAP < 11 || TIMEOUT < 2) begin : g_bad_param
    $error("fp_mac_feeder: K must be >=2, GAP >=11, TIMEOUT >=2");
  end
  assign last     = idx == (WK + 1)'(K - 1);
  assign w_rdy    = state == S_LOADW;
  assign d_rdy    = state == S_FILL;
  assign res_vld  = state == S_HOLD;
  assign busy     = state != S_IDLE;
  assign w_fire   = w_vld & w_rdy;
  assign d_fire   = d_vld & d_rdy;
  assign gap_done = gcnt == GW'(GAP);
  fp_mac_feeder_buf #(.WIDTH(WIDTH), .K(K)) u_wbuf (
    .clk_i (clk_i),
    .we    (w_fire),
    .waddr (idx[WK-1:0]),
    .wdata (w_data),
    .raddr (idx[WK-1:0]),
    .rdata (w_rd)
  );
  fp_mac_feeder_buf #(.WIDTH(WIDTH), .K(K)) u_dbuf (
    .clk_i (clk_i),
    .we    (d_fire),
    .waddr (idx[WK-1:0]),
    .wdata (d_data),
    .raddr (idx[WK-1:0]),
    .rdata (d_rd)
  );
  // State register
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else state <= nxt;
  end
  // Next state: a pending weight word always wins over reusing the loaded kernel
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = w_vld ? S_LOADW : loaded ? S_FILL : S_IDLE;
      S_LOADW: nxt = (w_fire && last) ? S_FILL : S_LOADW;
      S_FILL:  nxt = (d_fire && last) ? S_ISSUE : S_FILL;
      S_ISSUE: nxt = last ? S_WAIT : S_ISSUE;
      S_WAIT:  nxt = (mac_vld_i || tmo) ? S_HOLD : S_WAIT;
      S_HOLD:  nxt = res_rdy ? S_QUIET : S_HOLD;
      S_QUIET: nxt = gap_done ? S_IDLE : S_QUIET;
      default: nxt = S_IDLE;
    endcase
  end
  // Index/gap counters, kernel-loaded flag, registered MAC operands and result capture
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      idx       <= '0;
      gcnt      <= '0;
      loaded    <= 1'b0;
      mac_vld_o <= 1'b0;
      mac_win   <= '0;
      mac_din   <= '0;
      res_data  <= '0;
    end else begin
      if (state != nxt) idx <= '0;
      else if (w_fire || d_fire || state == S_ISSUE) idx <= idx + 1'b1;
      if (state == S_WAIT && nxt == S_HOLD) gcnt <= GW'(1);
      else if ((state == S_HOLD || state == S_QUIET) && !gap_done) gcnt <= gcnt + 1'b1;
      if (state == S_IDLE && w_vld) loaded <= 1'b0;
      else if (w_fire && last) loaded <= 1'b1;
      mac_vld_o <= state == S_ISSUE;
      mac_win   <= state == S_ISSUE ? w_rd : '0;
      mac_din   <= state == S_ISSUE ? d_rd : '0;
      if (state == S_WAIT && (mac_vld_i || tmo)) res_data <= mac_vld_i ? mac_acc_i : '0;
    end
  end
`ifdef FP_MAC_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt;
  logic err_q;
  assign tmo         = state == S_WAIT && tcnt == TW'(TIMEOUT - 1);
  assign err_timeout = err_q;
  // WAIT cycle counter and sticky timeout flag; a result arriving on the last cycle still wins
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= state == S_WAIT ? tcnt + 1'b1 : '0;
      if (tmo && !mac_vld_i) err_q <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule
